// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the E-stage multiply/divide unit.
//   - md_op_e    : operation codes driven by the decoder onto md_op
//   - md_state_e : sequencer states
//   - default busy latencies for multiply and divide
//   - md_is_multi: true for the ops that run multi-cycle (mult/multu/div/divu)
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE     = 2'd0,
    MD_MUL_BUSY = 2'd1,
    MD_DIV_BUSY = 2'd2
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Codes 0..3 are the multi-cycle ops; 6 and 7 are reserved no-ops.
  function automatic logic md_is_multi(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

endpackage

// File: rtl/md_seq.sv
// md_seq: sequencer for md_unit -- FSM plus busy down-counter.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low
//   start_mul  in   accept request for a multiply (qualified by caller)
//   start_div  in   accept request for a divide (qualified by caller)
//   cancel     in   abandon the in-flight op / suppress a start
//   accept     out  a new multi-cycle op is taken at this edge
//   busy       out  multi-cycle op in flight
//   commit     out  this edge writes the shadow result into HI/LO
module md_seq
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mul,
  input  logic start_div,
  input  logic cancel,
  output logic accept,
  output logic busy,
  output logic commit
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter is loaded with N-1 at the start edge, so it reaches zero
  // after N-1 more edges and the N-th edge commits: busy lasts exactly N.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    busy    = (state_q != MD_IDLE);
    commit  = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (!cancel && start_mul) begin
          state_d = MD_MUL_BUSY;
          cnt_d   = MUL_LOAD;
          accept  = 1'b1;
        end else if (!cancel && start_div) begin
          state_d = MD_DIV_BUSY;
          cnt_d   = DIV_LOAD;
          accept  = 1'b1;
        end
      end
      MD_MUL_BUSY, MD_DIV_BUSY: begin
        // cancel beats the commit edge: the shadow is simply never written back
        if (cancel) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = MD_IDLE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the E stage, holding architectural HI/LO.
// The result of mult/multu/div/divu is computed from A/B at the start edge
// into a shadow pair and written to HI/LO only at the end of the busy window,
// so mfhi/mflo keep seeing the old values while the op is in flight.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low; clears all state
//   start      in   E-stage instruction is an md op
//   md_op      in   md_op_e code (6,7 reserved -> no-op)
//   A, B       in   forwarded rs / rt operands
//   cancel     in   (only with MD_CANCEL_EN) abandon op / suppress start
//   busy       out  multi-cycle op in flight
//   stall_req  out  start of a multi-cycle op, or busy
//   hi, lo     out  architectural HI / LO
// Build option: define MD_CANCEL_EN to add the cancel input.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic cancel_w;
`ifdef MD_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  // Signed divide returning {remainder, quotient}. Divide-by-zero and the
  // single overflow case are pinned explicitly instead of left to '/'.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    a_s = a;
    b_s = b;
    if (b == 32'd0) begin
      return {a, 32'hFFFF_FFFF};
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      return {32'd0, 32'h8000_0000};
    end else begin
      q_s = a_s / b_s;
      r_s = a_s % b_s;
      return {r_s, q_s};
    end
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) begin
      return {a, 32'hFFFF_FFFF};
    end else begin
      return {a % b, a / b};
    end
  endfunction

  logic is_mul, is_div, accept, commit;

  assign is_mul    = start && (md_op == MD_MULT || md_op == MD_MULTU);
  assign is_div    = start && (md_op == MD_DIV  || md_op == MD_DIVU);
  assign stall_req = (start && md_is_multi(md_op)) || busy;

  md_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .start_mul (is_mul),
    .start_div (is_div),
    .cancel    (cancel_w),
    .accept    (accept),
    .busy      (busy),
    .commit    (commit)
  );

  logic signed [63:0] a_ext, b_ext, prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] res;

  assign a_ext  = {{32{A[31]}}, A};
  assign b_ext  = {{32{B[31]}}, B};
  assign prod_s = a_ext * b_ext;
  assign prod_u = {32'd0, A} * {32'd0, B};

  always_comb begin
    res = '0;
    unique case (md_op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV:   res = div_signed(A, B);
      MD_DIVU:  res = div_unsigned(A, B);
      default:  res = '0;
    endcase
  end

  logic [31:0] hi_q, hi_d, lo_q, lo_d, hi_s_q, hi_s_d, lo_s_q, lo_s_d;
  logic        mt_ok;

  // MTHI/MTLO act only when no op is in flight and not cancelled.
  assign mt_ok = start && !busy && !cancel_w;

  always_comb begin
    hi_s_d = hi_s_q;
    lo_s_d = lo_s_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (accept) begin
      hi_s_d = res[63:32];
      lo_s_d = res[31:0];
    end
    if (commit) begin
      hi_d = hi_s_q;
      lo_d = lo_s_q;
    end else if (mt_ok && md_op == MD_MTHI) begin
      hi_d = A;
    end else if (mt_ok && md_op == MD_MTLO) begin
      lo_d = A;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      hi_s_q <= '0;
      lo_s_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      hi_s_q <= hi_s_d;
      lo_s_q <= lo_s_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed testbench for md_unit with hand-computed results.
// Define MD_CANCEL_EN for both RTL and bench to exercise the cancel input.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
`ifdef MD_CANCEL_EN
  logic        cancel = 1'b0;
`endif
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .A         (A),
    .B         (B),
`ifdef MD_CANCEL_EN
    .cancel    (cancel),
`endif
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic exp_busy);
    check({tag, " busy"}, {31'd0, busy}, {31'd0, exp_busy});
    check({tag, " hi"}, hi, m_hi);
    check({tag, " lo"}, lo, m_lo);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    start = 1'b1; md_op = op; A = a; B = 32'h5555_5555;
    #1 check("mt stall_req", {31'd0, stall_req}, 32'd0);
    tick();
    start = 1'b0;
    if (op == MD_MTHI) m_hi = a; else m_lo = a;
    check_state("mt", 1'b0);
  endtask

  // Issue one multi-cycle op and check it stays busy exactly n cycles with
  // HI/LO frozen, then commits the expected result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] eh, input logic [31:0] el);
    start = 1'b1; md_op = op; A = a; B = b;
    #1 check({tag, " stall_req start"}, {31'd0, stall_req}, 32'd1);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check({tag, " in flight busy"}, {31'd0, busy}, 32'd1);
      check({tag, " in flight stall"}, {31'd0, stall_req}, 32'd1);
      check({tag, " in flight hi"}, hi, m_hi);
      check({tag, " in flight lo"}, lo, m_lo);
      tick();
    end
    m_hi = eh; m_lo = el;
    check_state({tag, " done"}, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_state("reset", 1'b0);
    reset = 1'b1;
    tick();
    check_state("after reset", 1'b0);

    mt(MD_MTLO, 32'h1111_1111);
    mt(MD_MTHI, 32'hDEAD_BEEF);

    run_op("mult",  MD_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",  MD_DIVU,  32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("divu by 0", MD_DIVU, 32'h1234, 32'd0, 10, 32'h1234, 32'hFFFF_FFFF);
    run_op("div by 0",  MD_DIV,  32'hFFFF_FF00, 32'd0, 10, 32'hFFFF_FF00, 32'hFFFF_FFFF);
    run_op("mult neg",  MD_MULT, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'd0);

    // reserved op: no stall, no state change
    start = 1'b1; md_op = 3'd6; A = 32'hCAFE_F00D; B = 32'd1;
    #1 check("reserved stall_req", {31'd0, stall_req}, 32'd0);
    tick();
    start = 1'b0;
    check_state("reserved", 1'b0);

    // overlap: DIV 100/7, with MULT starts in busy cycle 3 and on the commit edge
    start = 1'b1; md_op = MD_DIV; A = 32'd100; B = 32'd7;
    tick();
    for (int i = 1; i <= 10; i++) begin
      check("overlap busy", {31'd0, busy}, 32'd1);
      check("overlap hi frozen", hi, m_hi);
      if (i == 3 || i == 10) begin
        start = 1'b1; md_op = MD_MULT; A = 32'd5; B = 32'd5;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    m_hi = 32'd2; m_lo = 32'd14;
    check_state("overlap commit", 1'b0);
    tick();
    check_state("overlap no late op", 1'b0);

    // async reset in the middle of a MULT
    start = 1'b1; md_op = MD_MULT; A = 32'd3; B = 32'd4;
    tick();
    start = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check_state("async reset", 1'b0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check_state("no late commit", 1'b0);

`ifdef MD_CANCEL_EN
    mt(MD_MTHI, 32'hAAAA_0000);
    mt(MD_MTLO, 32'h0000_BBBB);
    start = 1'b1; md_op = MD_DIV; A = 32'd50; B = 32'd5;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("cancel pre busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check_state("cancel", 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check_state("cancel no commit", 1'b0);
    start = 1'b1; md_op = MD_MTHI; A = 32'h1234_5678; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    check_state("cancel mthi", 1'b0);
    start = 1'b1; md_op = MD_MULT; A = 32'd2; B = 32'd2; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    check_state("cancel start", 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
- Takes forwarded rs/rt operands from the E-stage bypass muxes and holds the architectural HI/LO registers.
- Multi-cycle mult/div operations run while the block reports busy; the hazard unit turns busy into en_PC/en_D/clr stalls for any later md instruction.
- mfhi/mflo read HI/LO combinationally in E.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (>=1).
- DIV_CYCLES, 10, busy duration for div/divu (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  E-stage instruction is an md op; sampled at clk edge.
- md_op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved (treated as no-op).
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- busy  out  1  multi-cycle op in flight.
- stall_req  out  1  combinational start&(md_op<=3) | busy; to hazard unit.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (reset=0, any time, async): busy=0, hi=0, lo=0, counter=0, FSM=IDLE, shadow results=0. Reset mid-operation discards the in-flight result.
- FSM states:
  - IDLE: on start with MULT/MULTU, go to MUL_BUSY. On DIV/DIVU, go to DIV_BUSY.
  - MUL_BUSY: return to IDLE when the counter hits 0.
  - DIV_BUSY: return to IDLE when the counter hits 0.
- Start of a multi-cycle op (edge T):
  - Compute the result from A/B at T into shadow hi_s/lo_s.
  - Load counter with N-1 (N = MULT_CYCLES or DIV_CYCLES).
  - busy=1 from after T.
- Counting: decrement each edge while busy. At edge T+N, commit hi<=hi_s, lo<=lo_s and set busy<=0 together. busy is high exactly N cycles. hi/lo keep their old values throughout busy.
- MTHI/MTLO: single cycle, no busy. At the sampling edge, hi<=A (or lo<=A); the other register is unchanged.
- start while busy: ignored (no state change). The hazard unit guarantees this does not occur; the bench checks it is harmless.
- start on the commit edge (busy=1, counter=0): ignored. A new op is accepted only when busy=0.
- MULT: signed 32x32 to 64; {hi,lo}=product.
- MULTU: unsigned 32x32 to 64; {hi,lo}=product.
- DIV (signed): lo=quotient truncated toward zero; hi=remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (B=0, DIV or DIVU): lo=0xFFFFFFFF, hi=A; normal N-cycle latency.
- Reserved md_op with start=1: no-op, stall_req follows busy only.

Optional Feature:
- Macro MD_CANCEL_EN.
- When defined:
  - Extra input port `cancel` (1 bit), for the future exception path.
  - cancel=1 at an edge while busy: FSM to IDLE, busy<=0, shadow discarded, hi/lo unchanged.
  - cancel=1 together with start in IDLE: the start is suppressed; an MTHI/MTLO also does not write.
  - cancel has priority over the commit edge.
- When undefined: no port; behaviour as above.

Decomposition:
- Shared package md_pkg:
  - md_op encodings (MD_MULT..MD_MTLO).
  - FSM state encodings (MD_IDLE, MD_MUL_BUSY, MD_DIV_BUSY).
  - Default latency constants.
- The same encodings are used by the decoder driving md_op.
- One natural sub-module, md_seq: FSM plus down-counter, emitting busy and a commit pulse.
- Arithmetic and HI/LO registers stay in md_unit.

Test Plan:
- Reset: reset=0 async mid-cycle during a MULT -> busy=0, hi=lo=0 immediately. After release, hi/lo stay 0 and no late commit occurs.
- MULT latency: start, MULT, A=0xFFFFFFFE(-2), B=3 -> busy high exactly 5 cycles. hi/lo unchanged until edge T+5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV signs: DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 -> lo=3, hi=1.
- Edge cases:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU A=0x1234, B=0 -> lo=0xFFFFFFFF, hi=0x1234.
- MT and stall_req:
  - MTHI A=0xDEADBEEF -> next cycle hi=0xDEADBEEF, busy never high, lo unchanged.
  - stall_req=1 in the start cycle of MULT and throughout busy; 0 for MTHI.
- Overlap: start DIV, then pulse start MULT in busy cycle 3 and on the commit edge -> both ignored. Final hi/lo equal the DIV result; busy falls after exactly 10 cycles.
- With MD_CANCEL_EN: start DIV, cancel in busy cycle 4 -> busy=0 next edge, hi/lo retain their pre-DIV values.
